// File: rtl/imm_pkg.sv
// Shared immediate-generator types, opcode constants and decode helpers.
// Build macro: IMM_GEN_ZICSR_EN enables the CSR-immediate (Z) format.
package imm_pkg;

    localparam int unsigned XlenDefault = 32;

    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpJal    = 7'h6F;
    localparam logic [6:0] OpSystem = 7'h73;

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtZ    = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        imm_fmt_e fmt;
        logic     illegal;
    } imm_dec_t;

    function automatic imm_dec_t decode_opcode(input logic [6:0] opcode, input logic f3_msb);
        imm_dec_t dec;
        dec.fmt     = FmtNone;
        dec.illegal = 1'b0;
        unique case (opcode)
            OpImm, OpLoad, OpJalr: dec.fmt = FmtI;
            OpStore:               dec.fmt = FmtS;
            OpBranch:              dec.fmt = FmtB;
            OpLui, OpAuipc:        dec.fmt = FmtU;
            OpJal:                 dec.fmt = FmtJ;
            OpSystem: begin
                if (f3_msb) begin
`ifdef IMM_GEN_ZICSR_EN
                    dec.fmt = FmtZ;
`else
                    dec.illegal = 1'b1;
`endif
                end
            end
            default:               dec.illegal = 1'b1;
        endcase
        return dec;
    endfunction

    // Result is already extended to 32 bits; callers sign-extend from bit 31 (0 for Z).
    function automatic logic [31:0] build_imm(input imm_fmt_e fmt, input logic [31:0] ins);
        logic [31:0] imm;
        imm = '0;
        unique case (fmt)
            FmtI: imm = {{20{ins[31]}}, ins[31:20]};
            FmtS: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FmtB: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FmtU: imm = {ins[31:12], 12'b0};
            FmtJ: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            FmtZ: imm = {27'b0, ins[19:15]};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/immediate_gen_pipe_if.sv
// Upstream/downstream handshake bundle for the immediate generator pipeline.
interface immediate_gen_pipe_if #(
    parameter int unsigned XLEN  = imm_pkg::XlenDefault,
    parameter int unsigned TAG_W = 8
);
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      instr_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  valid_i, instr_i, tag_i, flush_i, ready_i,
        output ready_o, valid_o, imm_o, fmt_o, illegal_o, tag_o
    );

    modport master (
        output valid_i, instr_i, tag_i, flush_i, ready_i,
        input  ready_o, valid_o, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_pipe_slice.sv
// One valid/ready register stage with synchronous flush; bubbles collapse.
module imm_pipe_slice #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);
    logic             valid_d, valid_q;
    logic [Width-1:0] data_d, data_q;

    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) data_d = in_data_i;
        end
        // Flush wins over both accept and hold.
        if (flush_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
endmodule

// File: rtl/immediate_gen_pipe.sv
// RV32 immediate generator, 1- or 2-stage valid/ready pipeline with tag passthrough.
// Build macro: IMM_GEN_ZICSR_EN (CSR-immediate format support, see imm_pkg).
module immediate_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN   = XlenDefault,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    immediate_gen_pipe_if.slave bus
);
    localparam int unsigned ResW = XLEN + 4 + TAG_W;

    logic [ResW-1:0] res;

    if (STAGES == 2) begin : g_two
        localparam int unsigned S1W = 29 + TAG_W;

        imm_dec_t        dec;
        imm_fmt_e        s1_fmt;
        logic [S1W-1:0]  s1_in, s1_out;
        logic            s1_valid, s1_ready;
        logic [31:0]     raw;
        logic [ResW-1:0] s2_in;

        // Stage 1 keeps only instr[31:7]; the opcode is consumed by the decode.
        assign dec   = decode_opcode(bus.instr_i[6:0], bus.instr_i[14]);
        assign s1_in = {dec.fmt, dec.illegal, bus.instr_i[31:7], bus.tag_i};

        imm_pipe_slice #(.Width(S1W)) u_s1 (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (bus.flush_i),
            .in_valid_i (bus.valid_i),
            .in_ready_o (bus.ready_o),
            .in_data_i  (s1_in),
            .out_valid_o(s1_valid),
            .out_ready_i(s1_ready),
            .out_data_o (s1_out)
        );

        assign s1_fmt = imm_fmt_e'(s1_out[S1W-1 -: 3]);
        assign raw    = build_imm(s1_fmt, {s1_out[TAG_W +: 25], 7'b0});
        assign s2_in  = {XLEN'($signed(raw)), s1_out[S1W-1 -: 4], s1_out[TAG_W-1:0]};

        imm_pipe_slice #(.Width(ResW)) u_s2 (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (bus.flush_i),
            .in_valid_i (s1_valid),
            .in_ready_o (s1_ready),
            .in_data_i  (s2_in),
            .out_valid_o(bus.valid_o),
            .out_ready_i(bus.ready_i),
            .out_data_o (res)
        );
    end else begin : g_one
        imm_dec_t        dec;
        logic [31:0]     raw;
        logic [ResW-1:0] s1_in;

        assign dec   = decode_opcode(bus.instr_i[6:0], bus.instr_i[14]);
        assign raw   = build_imm(dec.fmt, bus.instr_i);
        assign s1_in = {XLEN'($signed(raw)), dec.fmt, dec.illegal, bus.tag_i};

        imm_pipe_slice #(.Width(ResW)) u_s1 (
            .clk        (clk),
            .reset      (reset),
            .flush_i    (bus.flush_i),
            .in_valid_i (bus.valid_i),
            .in_ready_o (bus.ready_o),
            .in_data_i  (s1_in),
            .out_valid_o(bus.valid_o),
            .out_ready_i(bus.ready_i),
            .out_data_o (res)
        );
    end

    assign bus.imm_o     = res[ResW-1 -: XLEN];
    assign bus.fmt_o     = res[TAG_W+3 -: 3];
    assign bus.illegal_o = res[TAG_W];
    assign bus.tag_o     = res[TAG_W-1:0];
endmodule

// File: tb/tb_immediate_gen_pipe.sv
// Directed self-checking bench for immediate_gen_pipe (XLEN 32 and 64, STAGES=2).
module tb_immediate_gen_pipe;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    immediate_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus ();
    immediate_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus64 ();

    immediate_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(8)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    immediate_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(8)) u_dut64 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus64)
    );

    // The 64-bit instance shadows the 32-bit one cycle for cycle.
    assign bus64.valid_i = bus.valid_i;
    assign bus64.instr_i = bus.instr_i;
    assign bus64.tag_i   = bus.tag_i;
    assign bus64.flush_i = bus.flush_i;
    assign bus64.ready_i = bus.ready_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] ins, input logic [7:0] tg,
                           input logic [31:0] e_imm, input logic [63:0] e_imm64,
                           input logic [2:0] e_fmt, input logic e_ill);
        bus.valid_i = 1'b1;
        bus.instr_i = ins;
        bus.tag_i   = tg;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.instr_i = 32'h0;
        check({name, "_lat1"}, {63'b0, bus.valid_o}, 64'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, {63'b0, bus.valid_o}, 64'd1);
        check({name, "_imm"}, {32'b0, bus.imm_o}, {32'b0, e_imm});
        check({name, "_fmt"}, {61'b0, bus.fmt_o}, {61'b0, e_fmt});
        check({name, "_ill"}, {63'b0, bus.illegal_o}, {63'b0, e_ill});
        check({name, "_tag"}, {56'b0, bus.tag_o}, {56'b0, tg});
        check({name, "_imm64"}, bus64.imm_o, e_imm64);
    endtask

    initial begin
        int          sent;
        int          got;
        bit          prev_stall;
        bit          saw_full;
        logic [31:0] held_imm;
        logic [7:0]  held_tag;

        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.instr_i = 32'h0;
        bus.tag_i   = 8'h0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {63'b0, bus.valid_o}, 64'd0);
        check("rst_imm", {32'b0, bus.imm_o}, 64'd0);
        check("rst_fmt", {61'b0, bus.fmt_o}, 64'd0);
        check("rst_ill", {63'b0, bus.illegal_o}, 64'd0);
        check("rst_tag", {56'b0, bus.tag_o}, 64'd0);
        check("rst_imm64", bus64.imm_o, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", {63'b0, bus.ready_o}, 64'd1);
        @(posedge clk); #1;

        run_vec("addi", 32'hFFF00093, 8'h11, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        run_vec("lui", 32'h123450B7, 8'h12, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0);
        run_vec("beq", 32'hFE000EE3, 8'h13, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        run_vec("jal", 32'h0010006F, 8'h14, 32'h00000800, 64'h0000000000000800, 3'd5, 1'b0);
        run_vec("sw", 32'h00112623, 8'h15, 32'h0000000C, 64'h000000000000000C, 3'd2, 1'b0);
        run_vec("auipc", 32'h00001517, 8'h16, 32'h00001000, 64'h0000000000001000, 3'd4, 1'b0);
        run_vec("lw", 32'h00402083, 8'h17, 32'h00000004, 64'h0000000000000004, 3'd1, 1'b0);
        run_vec("jalr", 32'h80008067, 8'h18, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0);
        run_vec("bad", 32'hFFFFFF8B, 8'h19, 32'h00000000, 64'h0, 3'd0, 1'b1);
        run_vec("ecall", 32'h00000073, 8'h1A, 32'h00000000, 64'h0, 3'd0, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
        run_vec("csrrwi", 32'h300FD073, 8'h1B, 32'h0000001F, 64'h1F, 3'd6, 1'b0);
`else
        run_vec("csrrwi", 32'h300FD073, 8'h1B, 32'h00000000, 64'h0, 3'd0, 1'b1);
`endif

        // Stream of six tagged words with the consumer stalled for cycles 3-5.
        @(posedge clk); #1;
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        saw_full   = 1'b0;
        held_imm   = 32'h0;
        held_tag   = 8'h0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus.ready_i = !(cyc >= 3 && cyc <= 5);
            bus.valid_i = (sent < 6);
            bus.instr_i = 32'h00000093 | (32'(sent) << 20);
            bus.tag_i   = 8'(sent);
            #1;
            if (prev_stall) begin
                check("hold_valid", {63'b0, bus.valid_o}, 64'd1);
                check("hold_imm", {32'b0, bus.imm_o}, {32'b0, held_imm});
                check("hold_tag", {56'b0, bus.tag_o}, {56'b0, held_tag});
            end
            if (bus.valid_o && bus.ready_i) begin
                check("stream_tag", {56'b0, bus.tag_o}, 64'(got));
                check("stream_imm", {32'b0, bus.imm_o}, 64'(got));
                got++;
            end
            prev_stall = bus.valid_o && !bus.ready_i;
            held_imm   = bus.imm_o;
            held_tag   = bus.tag_o;
            if (!bus.ready_o) saw_full = 1'b1;
            if (bus.valid_i && bus.ready_o) sent++;
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        check("stream_sent", 64'(sent), 64'd6);
        check("stream_got", 64'(got), 64'd6);
        check("stream_full", {63'b0, saw_full}, 64'd1);

        // Two words in flight (consumer stalled) plus a new one, all killed by flush.
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.instr_i = 32'h00A00093;
        bus.tag_i   = 8'hA0;
        @(posedge clk); #1;
        bus.instr_i = 32'h00B00093;
        bus.tag_i   = 8'hA1;
        @(posedge clk); #1;
        check("pre_flush_valid", {63'b0, bus.valid_o}, 64'd1);
        bus.instr_i = 32'h00C00093;
        bus.tag_i   = 8'hA2;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("flush_gone", {63'b0, bus.valid_o}, 64'd0);
            @(posedge clk); #1;
        end
        run_vec("post_flush", 32'h00D00093, 8'hA3, 32'h0000000D, 64'h0D, 3'd1, 1'b0);

        // Asynchronous reset while a result is presented.
        @(posedge clk); #1;
        bus.valid_i = 1'b1;
        bus.instr_i = 32'hFFF00093;
        bus.tag_i   = 8'h55;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(posedge clk); #1;
        check("mid_valid", {63'b0, bus.valid_o}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", {63'b0, bus.valid_o}, 64'd0);
        check("async_imm", {32'b0, bus.imm_o}, 64'd0);
        check("async_tag", {56'b0, bus.tag_o}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rst2_ready", {63'b0, bus.ready_o}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst2_gone", {63'b0, bus.valid_o}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/immediate_gen_pipe.md
IMMEDIATE_GEN_PIPE -- requirements
Module: immediate_gen_pipe

Interface
REQ-001 Parameter: XLEN, 32, immediate/output width; legal values 32 or 64.
REQ-002 Parameter: STAGES, 2, pipeline depth; legal values 1 or 2.
REQ-003 Parameter: TAG_W, 8, width of the sideband tag passed through unchanged.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid_i  input  1  instruction word on instr_i is valid.
REQ-007 ready_o  output  1  block accepts the input this cycle.
REQ-008 instr_i  input  32  raw RV32 instruction word.
REQ-009 tag_i  input  TAG_W  sideband tag (e.g. ROB/PC index).
REQ-010 flush_i  input  1  synchronous kill of all in-flight entries.
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 imm_o  output  XLEN  assembled immediate.
REQ-014 fmt_o  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-015 illegal_o  output  1  opcode is not recognised.
REQ-016 tag_o  output  TAG_W  tag of the result.

Function
REQ-017 Decode on instr_i[6:0]: 0x13/0x03/0x67 -> I; 0x23 -> S; 0x63 -> B; 0x37/0x17 -> U; 0x6F -> J; 0x73 -> see REQ-022; any other opcode -> NONE, illegal_o=1, imm_o=0.
REQ-018 I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); U = sext({instr[31:12],12'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); sign extension uses instr[31] up to XLEN.
REQ-019 Latency from accept (valid_i & ready_o) to valid_o is exactly STAGES cycles when ready_i stays high; throughput is one result per cycle.
REQ-020 Each stage holds one entry; ready_o = !valid(last stage) | ready_i, propagated per stage (bubbles collapse); no combinational path from valid_i to valid_o.
REQ-021 While valid_o=1 and ready_i=0, imm_o, fmt_o, illegal_o and tag_o hold stable; no entry is dropped or duplicated.
REQ-022 Opcode 0x73: if funct3[2]=0, output NONE, imm 0, illegal_o=0; if funct3[2]=1, behaviour per REQ-029/REQ-030.
REQ-023 flush_i=1 clears every stage valid bit at the next edge; an input presented in the same cycle is discarded; flush has priority over accept and over hold.
REQ-024 When valid_o=0, imm_o, fmt_o, illegal_o and tag_o are don't-care for consumers but must not be X after reset.

Reset
REQ-025 reset=1 immediately (asynchronously) clears all stage valid bits, so valid_o=0.
REQ-026 reset clears all data registers, so imm_o=0, fmt_o=0, illegal_o=0 and tag_o=0.
REQ-027 ready_o=1 on the first cycle after reset deasserts.
REQ-028 reset asserted mid-stream discards all in-flight entries; no result for them ever appears.

Configuration
REQ-029 With IMM_GEN_ZICSR_EN defined, 0x73 with funct3[2]=1 yields fmt Z and imm_o = zero-extended instr[19:15].
REQ-030 Without IMM_GEN_ZICSR_EN, that case yields fmt NONE, imm_o=0 and illegal_o=1.

Structure
REQ-031 Shared package imm_pkg holds the format enumeration, the opcode constants and the XLEN default.
REQ-032 One sub-module, imm_pipe_slice: a single valid/ready register stage with flush, instantiated STAGES times.
REQ-033 With STAGES=2, slice 1 registers the decoded format and instr; slice 2 registers the assembled immediate.

Verification
REQ-034 0xFFF00093 (addi -1), XLEN=32, STAGES=2 -> 2 cycles later: valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1.
REQ-035 0x123450B7 (lui) -> imm_o=0x12345000, fmt_o=4; 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt_o=3; 0x0010006F (jal +2048) -> 0x00000800, fmt_o=5; with XLEN=64, addi -1 -> 0xFFFFFFFFFFFFFFFF.
REQ-036 0x300FD073 (csrrwi imm 31): with macro -> imm_o=0x1F, fmt_o=6, illegal_o=0; without macro -> imm_o=0, illegal_o=1.
REQ-037 Stream of 6 tagged words with ready_i low for cycles 3-5 -> outputs hold, ready_o falls once all stages are full, tags 0-5 emerge in order with no loss.
REQ-038 flush_i pulsed while 2 entries are in flight plus a new valid_i -> none of the 3 appear; the next accepted word emerges after STAGES cycles; reset mid-stream -> valid_o drops asynchronously.
